// File: rtl/babbage_pkg.sv
// Shared constants and types for the Babbage difference extractor.
// EXTRA_SAMPLES only matters when BABBAGE_VERIFY_EN is defined.
package babbage_pkg;

  localparam int WIDTH         = 32;
  localparam int DEGREE        = 5;
  localparam int EXTRA_SAMPLES = 2;

  typedef logic signed [WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_VERIFY  = 2'd2,
    S_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/babbage_diff_stage.sv
// One link of the difference chain: diagonal register D_j and e_{j+1} = e_j - D_j.
module babbage_diff_stage
  import babbage_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] e_in,
  output logic [WIDTH-1:0] e_out
);

  word_t d;

  always_ff @(posedge clk) begin
    if (!reset)
      d <= '0;
    else if (load)
      d <= e_in;
  end

  assign e_out = e_in - d;

endmodule

// File: rtl/babbage_diff_extractor.sv
// Recovers forward differences at x=0 from samples p(0)..p(DEGREE).
// Optional BABBAGE_VERIFY_EN checks EXTRA_SAMPLES more samples for a zero Δ^(DEGREE+1).
//
// state     | meaning
// S_IDLE    | waiting for start
// S_COLLECT | accepting p(0)..p(DEGREE), capturing Δ^k p(0)
// S_VERIFY  | accepting extra samples, flagging nonzero Δ^(DEGREE+1)
// S_DONE    | results valid until out_ack
module babbage_diff_extractor
  import babbage_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic             out_ack,
  output logic [WIDTH-1:0] u_out,
  output logic [WIDTH-1:0] v_out,
  output logic [WIDTH-1:0] w_out,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] z_out,
  output logic             out_valid,
  output logic             busy,
  output logic             degree_err
);

`ifdef BABBAGE_VERIFY_EN
  localparam int NSTAGE = DEGREE + 1;
  localparam int LAST_K = DEGREE + EXTRA_SAMPLES;
`else
  localparam int NSTAGE = DEGREE;
`endif
  localparam int KW = 4;

  state_t          state, state_nxt;
  logic [KW-1:0]   k;
  word_t           e   [0:NSTAGE];
  word_t           res [0:DEGREE];
  logic            accept;
  logic            start_ok;

  assign sample_ready = (state == S_COLLECT) || (state == S_VERIFY);
  assign accept       = sample_valid && sample_ready;
  assign start_ok     = (state == S_IDLE) && start;
  assign busy         = (state != S_IDLE);
  assign out_valid    = (state == S_DONE);
  assign e[0]         = sample_in;

  // D_j loads only once sample j has arrived; in VERIFY every stage keeps sliding.
  for (genvar j = 0; j < NSTAGE; j++) begin : g_stage
    babbage_diff_stage u_stage (
      .clk   (clk),
      .reset (reset),
      .load  (accept && ((state == S_VERIFY) || (k >= KW'(j)))),
      .e_in  (e[j]),
      .e_out (e[j+1])
    );
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_COLLECT;
      S_COLLECT: begin
        if (accept && (k == KW'(DEGREE))) begin
`ifdef BABBAGE_VERIFY_EN
          state_nxt = S_VERIFY;
`else
          state_nxt = S_DONE;
`endif
        end
      end
      S_VERIFY: begin
`ifdef BABBAGE_VERIFY_EN
        if (accept && (k == KW'(LAST_K))) state_nxt = S_DONE;
`else
        state_nxt = S_IDLE;
`endif
      end
      S_DONE:    if (out_ack) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      k     <= '0;
      for (int i = 0; i <= DEGREE; i++) res[i] <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok)
        k <= '0;
      else if (accept)
        k <= k + KW'(1);
      if (accept && (state == S_COLLECT)) begin
        for (int i = 0; i <= DEGREE; i++)
          if (k == KW'(i)) res[i] <= e[i];
      end
    end
  end

`ifdef BABBAGE_VERIFY_EN
  always_ff @(posedge clk) begin
    if (!reset)
      degree_err <= 1'b0;
    else if (start_ok)
      degree_err <= 1'b0;
    else if (accept && (state == S_VERIFY) && (e[NSTAGE] != '0))
      degree_err <= 1'b1;
  end
`else
  assign degree_err = 1'b0;
`endif

  assign u_out = res[0];
  assign v_out = res[1];
  assign w_out = res[2];
  assign x_out = res[3];
  assign y_out = res[4];
  assign z_out = res[5];

endmodule

// File: tb/tb_babbage_diff_extractor.sv
// Randomized self-checking bench: a difference-table model predicts every output each cycle.
module tb_babbage_diff_extractor;
  import babbage_pkg::*;

`ifdef BABBAGE_VERIFY_EN
  localparam int NS = DEGREE + 1 + EXTRA_SAMPLES;
`else
  localparam int NS = DEGREE + 1;
`endif

  logic             clk = 1'b0;
  logic             reset, start, sample_valid, out_ack;
  logic [WIDTH-1:0] sample_in;
  logic             sample_ready, out_valid, busy, degree_err;
  logic [WIDTH-1:0] u_out, v_out, w_out, x_out, y_out, z_out;

  babbage_diff_extractor dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .out_ack      (out_ack),
    .u_out        (u_out),
    .v_out        (v_out),
    .w_out        (w_out),
    .x_out        (x_out),
    .y_out        (y_out),
    .z_out        (z_out),
    .out_valid    (out_valid),
    .busy         (busy),
    .degree_err   (degree_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_mode;          // 0 idle, 1 collect, 2 verify, 3 done
  int          mcnt;
  logic [31:0] ms    [0:7];
  logic [31:0] m_res [0:5];
  logic        m_err;
  bit          chk_en = 0;

  // k-th forward difference of ms[first..first+k], taken as a plain difference table
  function automatic logic [31:0] kdiff(input int first, input int kk);
    logic [31:0] t [0:7];
    for (int i = 0; i <= kk; i++) t[i] = ms[first + i];
    for (int lv = 1; lv <= kk; lv++)
      for (int i = 0; i <= kk - lv; i++) t[i] = t[i+1] - t[i];
    return t[0];
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_mode = 0;
      mcnt   = 0;
      m_err  = 1'b0;
      for (int i = 0; i < 6; i++) m_res[i] = '0;
    end else begin
      case (m_mode)
        0: if (start) begin m_mode = 1; mcnt = 0; m_err = 1'b0; end
        1, 2: if (sample_valid) begin
          ms[mcnt] = sample_in;
          mcnt++;
          if (mcnt <= 6) m_res[mcnt-1] = kdiff(0, mcnt - 1);
          else if (kdiff(mcnt - 7, 6) != 0) m_err = 1'b1;
          if (mcnt == NS) m_mode = 3;
          else if (mcnt == 6) m_mode = 2;
        end
        3: if (out_ack) m_mode = 0;
        default: m_mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid",    out_valid,    32'(m_mode == 3));
      chk("busy",         busy,         32'(m_mode != 0));
      chk("sample_ready", sample_ready, 32'(m_mode == 1 || m_mode == 2));
      chk("u_out", u_out, m_res[0]);
      chk("v_out", v_out, m_res[1]);
      chk("w_out", w_out, m_res[2]);
      chk("x_out", x_out, m_res[3]);
      chk("y_out", y_out, m_res[4]);
      chk("z_out", z_out, m_res[5]);
      chk("degree_err", degree_err, 32'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] seq [0:7];

  // gap_mode: 0 back-to-back, 1 alternate valid/idle, 2 random gaps
  task automatic run_seq(input int gap_mode, input bit poke_start, input int abort_after);
    int n = 0;
    int cyc = 0;
    @(posedge clk); #1;
    start = 1'b1; sample_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    while (n < NS) begin
      if (n == abort_after) begin
        reset = 1'b0; sample_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        return;
      end
      if ((gap_mode == 1 && cyc[0]) || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
        sample_valid = 1'b0;
        sample_in    = $urandom;
      end else begin
        sample_valid = 1'b1;
        sample_in    = seq[n];
        n++;
      end
      start = poke_start && (n == 3);
      cyc++;
      @(posedge clk); #1;
    end
    sample_valid = 1'b0;
    start        = 1'b0;
  endtask

  task automatic do_ack(input int hold);
    repeat (hold) begin
      sample_valid = 1'($urandom_range(0, 1));
      sample_in    = $urandom;
      @(posedge clk); #1;
    end
    out_ack      = 1'b1;
    start        = 1'($urandom_range(0, 1));
    sample_valid = 1'b0;
    @(posedge clk); #1;
    out_ack = 1'b0;
    start   = 1'b0;
    sample_valid = 1'b1;
    sample_in    = $urandom;
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic load_x5();
    for (int i = 0; i < 8; i++) seq[i] = 32'(i * i * i * i * i);
  endtask

  task automatic pin_x5(input string tag);
    chk({tag, "_latency"}, out_valid, 32'd1);
    chk({tag, "_u"}, u_out, 32'd0);
    chk({tag, "_v"}, v_out, 32'd1);
    chk({tag, "_w"}, w_out, 32'd30);
    chk({tag, "_x"}, x_out, 32'd150);
    chk({tag, "_y"}, y_out, 32'd240);
    chk({tag, "_z"}, z_out, 32'd120);
  endtask

  initial begin
    logic [31:0] p7;
    reset = 1'b0; start = 1'b0; sample_valid = 1'b0; out_ack = 1'b0; sample_in = '0;
    @(posedge clk); #1;
    chk_en = 1;
    start = 1'b1;            // ignored while reset is low
    @(posedge clk); #1;
    start = 1'b0;
    reset = 1'b1;
    chk("reset_busy", busy, 32'd0);
    chk("reset_u", u_out, 32'd0);
    chk("reset_valid", out_valid, 32'd0);

    load_x5();
    run_seq(0, 0, -1);
    pin_x5("x5");
    p7 = u_out + 7 * v_out + 21 * w_out + 35 * x_out + 35 * y_out + 21 * z_out;
    chk("roundtrip_p7", p7, 32'd16807);
    do_ack(3);

    for (int i = 0; i < 8; i++) seq[i] = 32'd7;
    run_seq(0, 0, -1);
    chk("const_u", u_out, 32'd7);
    chk("const_v", v_out, 32'd0);
    chk("const_z", z_out, 32'd0);
    do_ack(1);

    for (int i = 0; i < 8; i++) seq[i] = -32'(i);
    run_seq(1, 0, -1);
    chk("negx_u", u_out, 32'd0);
    chk("negx_v", v_out, 32'hFFFF_FFFF);
    chk("negx_w", w_out, 32'd0);
    chk("negx_z", z_out, 32'd0);
    do_ack(2);

    load_x5();
    run_seq(0, 0, 3);
    chk("abort_busy", busy, 32'd0);
    chk("abort_u", u_out, 32'd0);
    run_seq(2, 1, -1);
    pin_x5("x5_after_abort");
    do_ack(0);

`ifdef BABBAGE_VERIFY_EN
    load_x5();
    run_seq(0, 0, -1);
    chk("verify_ok_err", degree_err, 32'd0);
    do_ack(1);
    seq[6] = 32'd7777;
    run_seq(2, 0, -1);
    chk("verify_bad_err", degree_err, 32'd1);
    pin_x5("verify_bad");
    do_ack(1);
`endif

    for (int r = 0; r < 30; r++) begin
      if (r[0]) begin
        for (int i = 0; i < 8; i++) seq[i] = $urandom;
      end else begin
        logic [31:0] c [0:5];
        for (int j = 0; j < 6; j++) c[j] = 32'($urandom_range(0, 200)) - 32'd100;
        for (int i = 0; i < 8; i++) begin
          logic [31:0] acc = '0;
          for (int j = 5; j >= 0; j--) acc = acc * 32'(i) + c[j];
          seq[i] = acc;
        end
      end
      run_seq(r % 3, (r % 4) == 1, (r % 7 == 6) ? int'($urandom_range(0, NS - 1)) : -1);
      if (out_valid) do_ack($urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
